// File: rtl/int_ctrl.sv
// SM83 interrupt controller: IF/IE registers, IME with delayed EI, HALT wake,
// and the five M-cycle dispatch sequencer that drives the control unit.
module int_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        instr_boundary,
    input  logic        ei,
    input  logic        di,
    input  logic        reti,
    input  logic        halted,
    input  logic [4:0]  irq_src,
    input  logic [15:0] bus_addr,
    input  logic        bus_we,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    output logic        bus_sel,
    output logic        wake,
    output logic        int_busy,
    output logic        sp_dec,
    output logic        push_pch,
    output logic        push_pcl,
    output logic        vec_load,
    output logic [15:0] vector,
    output logic        ime
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        W1   = 3'd1,
        W2   = 3'd2,
        PH   = 3'd3,
        PL   = 3'd4,
        LD   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  if_q, if_d;
    logic [7:0]  ie_q;
    logic        ime_q;
    logic        ei_pend_q;
    logic [2:0]  n_q;
    logic        vec_valid_q;
    logic [15:0] vector_q;

    logic [4:0]  pending;
    logic [2:0]  sel_n;
    logic        found;
    logic        sel_if, sel_ie;
    logic        dispatch_go;
    logic        if_clr;

    // HALT only matters to the control unit, which leaves HALT on wake.
    logic        unused_halted;
    assign unused_halted = halted;

    assign sel_if   = (bus_addr == 16'hFF0F);
    assign sel_ie   = (bus_addr == 16'hFFFF);
    assign bus_sel  = sel_if | sel_ie;
    assign pending  = ie_q[4:0] & if_q;
    assign wake     = |pending;
    assign int_busy = (state_q != IDLE);
    assign ime      = ime_q;
    assign vector   = vector_q;

    assign dispatch_go = (state_q == IDLE) && step && instr_boundary && ime_q && (|pending);
    assign if_clr      = (state_q == LD) && step && vec_valid_q;

    always_comb begin
        bus_rdata = '0;
        if (sel_if)
            bus_rdata = {3'b111, if_q};
        else if (sel_ie)
            bus_rdata = ie_q;
    end

    always_comb begin
        sel_n = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (pending[i] && !found) begin
                sel_n = 3'(i);
                found = 1'b1;
            end
        end
    end

    // Request pulses are applied last so they win over both a CPU write and the dispatch clear.
    always_comb begin
        if_d = if_q;
        if (if_clr)
            if_d[n_q] = 1'b0;
        if (bus_we && sel_if)
            if_d = bus_wdata[4:0];
        if_d = if_d | irq_src;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_q <= '0;
            ie_q <= '0;
        end else begin
            if_q <= if_d;
            if (bus_we && sel_ie)
                ie_q <= bus_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ime_q     <= 1'b0;
            ei_pend_q <= 1'b0;
        end else if (dispatch_go) begin
            ime_q <= 1'b0;
        end else if (step && !int_busy) begin
            if (di) begin
                ime_q     <= 1'b0;
                ei_pend_q <= 1'b0;
            end else begin
                if (reti)
                    ime_q <= 1'b1;
                if (ei_pend_q && instr_boundary) begin
                    ime_q     <= 1'b1;
                    ei_pend_q <= 1'b0;
                end
                if (ei)
                    ei_pend_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            vec_valid_q <= 1'b0;
            vector_q    <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == PL) && step) begin
                n_q         <= sel_n;
                vec_valid_q <= |pending;
                vector_q    <= (|pending) ? (16'h0040 + {10'd0, sel_n, 3'b000}) : 16'h0000;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sp_dec   = 1'b0;
        push_pch = 1'b0;
        push_pcl = 1'b0;
        vec_load = 1'b0;
        unique case (state_q)
            IDLE: if (dispatch_go) state_d = W1;
            W1:   if (step) state_d = W2;
            W2: begin
                sp_dec = 1'b1;
                if (step) state_d = PH;
            end
            PH: begin
                sp_dec   = 1'b1;
                push_pch = 1'b1;
                if (step) state_d = PL;
            end
            PL: begin
                push_pcl = 1'b1;
                if (step) state_d = LD;
            end
            LD: begin
                vec_load = 1'b1;
                if (step) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: register table vectors through a scoreboard, then
// hand-written dispatch, EI delay, cancel, wake, override and reset sequences.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        step, instr_boundary, ei, di, reti, halted;
    logic [4:0]  irq_src;
    logic [15:0] bus_addr;
    logic        bus_we;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_sel, wake, int_busy, sp_dec, push_pch, push_pcl, vec_load;
    logic [15:0] vector;
    logic        ime;
    logic [4:0]  strobes;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign strobes = {int_busy, sp_dec, push_pch, push_pcl, vec_load};

    int_ctrl dut (
        .clk(clk), .rst(rst), .step(step), .instr_boundary(instr_boundary),
        .ei(ei), .di(di), .reti(reti), .halted(halted), .irq_src(irq_src),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_sel(bus_sel), .wake(wake), .int_busy(int_busy),
        .sp_dec(sp_dec), .push_pch(push_pch), .push_pcl(push_pcl),
        .vec_load(vec_load), .vector(vector), .ime(ime)
    );

    typedef struct {
        string       nm;
        logic [15:0] val;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [4:0]  irq;
        logic [7:0]  exp_rd;
        logic        exp_wake;
        logic        exp_sel;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic sb_push(input string nm, input logic [15:0] v);
        exp_t e;
        e.nm  = nm;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic [15:0] act);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0x%0h expected none", act);
        end else begin
            e = sb.pop_front();
            check(e.nm, act, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mstep(input logic b, input logic e, input logic d, input logic r,
                         input logic [4:0] irq);
        step = 1'b1; instr_boundary = b; ei = e; di = d; reti = r; irq_src = irq;
        tick();
        step = 1'b0; instr_boundary = 1'b0; ei = 1'b0; di = 1'b0; reti = 1'b0; irq_src = '0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus_addr = a; bus_wdata = d; bus_we = 1'b1;
        tick();
        bus_we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        bus_addr = a;
        #1;
        d = bus_rdata;
    endtask

    task automatic pulse_irq(input logic [4:0] irq);
        irq_src = irq;
        tick();
        irq_src = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic [4:0] exp_strb[6];

        tbl[0] = '{16'hFF0F, 8'hFF, 5'h00, 8'hFF, 1'b0, 1'b1};
        tbl[1] = '{16'hFFFF, 8'h05, 5'h00, 8'h05, 1'b1, 1'b1};
        tbl[2] = '{16'hFF0F, 8'h00, 5'h00, 8'hE0, 1'b0, 1'b1};
        tbl[3] = '{16'hFF0F, 8'h00, 5'h01, 8'hE1, 1'b1, 1'b1};
        tbl[4] = '{16'hFFFF, 8'hE0, 5'h00, 8'hE0, 1'b0, 1'b1};
        tbl[5] = '{16'hFF0F, 8'h1F, 5'h00, 8'hFF, 1'b0, 1'b1};
        tbl[6] = '{16'hFFFF, 8'h10, 5'h00, 8'h10, 1'b1, 1'b1};
        tbl[7] = '{16'hFF80, 8'hAA, 5'h00, 8'h00, 1'b1, 1'b0};

        exp_strb[0] = 5'b10000;
        exp_strb[1] = 5'b11000;
        exp_strb[2] = 5'b11100;
        exp_strb[3] = 5'b10010;
        exp_strb[4] = 5'b10001;
        exp_strb[5] = 5'b00000;

        rst = 1'b0; step = 1'b0; instr_boundary = 1'b0; ei = 1'b0; di = 1'b0;
        reti = 1'b0; halted = 1'b0; irq_src = '0; bus_addr = '0; bus_we = 1'b0;
        bus_wdata = '0;
        #2;
        check("reset_strobes", 16'(strobes), 16'h0);
        check("reset_vector", vector, 16'h0000);
        check("reset_ime", 16'(ime), 16'h0);
        check("reset_wake", 16'(wake), 16'h0);
        rd(16'hFF0F, d); check("reset_if", 16'(d), 16'h00E0);
        rd(16'hFFFF, d); check("reset_ie", 16'(d), 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Register vectors with IME=0: writes, IRQ-over-write, unmapped address.
        for (int i = 0; i < 8; i++) begin
            bus_addr = tbl[i].addr; bus_wdata = tbl[i].wdata; bus_we = 1'b1;
            irq_src = tbl[i].irq;
            sb_push($sformatf("tbl_rd[%0d]", i), 16'(tbl[i].exp_rd));
            sb_push($sformatf("tbl_wake[%0d]", i), 16'(tbl[i].exp_wake));
            sb_push($sformatf("tbl_sel[%0d]", i), 16'(tbl[i].exp_sel));
            tick();
            bus_we = 1'b0; irq_src = '0;
            sb_pop(16'(bus_rdata));
            sb_pop(16'(wake));
            sb_pop(16'(bus_sel));
        end

        // Full dispatch of VBlank with Timer also pending.
        do_reset();
        mstep(1'b0, 1'b0, 1'b0, 1'b1, 5'h00);
        check("reti_ime", 16'(ime), 16'h1);
        wr(16'hFFFF, 8'h05);
        pulse_irq(5'h05);
        for (int i = 0; i < 6; i++) begin
            sb_push($sformatf("disp_step[%0d]", i), 16'(exp_strb[i]));
            sb_push($sformatf("disp_hold[%0d]", i), 16'(exp_strb[i]));
            mstep(i == 0, 1'b0, 1'b0, 1'b0, 5'h00);
            sb_pop(16'(strobes));
            tick();
            sb_pop(16'(strobes));
            if (i == 4) check("disp_vector_ld", vector, 16'h0040);
        end
        check("disp_vector", vector, 16'h0040);
        check("disp_ime", 16'(ime), 16'h0);
        rd(16'hFF0F, d); check("disp_if", 16'(d), 16'h00E4);

        // EI delay: IME rises on the next boundary, dispatch on the one after.
        do_reset();
        wr(16'hFFFF, 8'h01);
        wr(16'hFF0F, 8'h01);
        mstep(1'b0, 1'b1, 1'b0, 1'b0, 5'h00);
        mstep(1'b0, 1'b0, 1'b0, 1'b0, 5'h00);
        check("ei_nonbound_ime", 16'(ime), 16'h0);
        mstep(1'b1, 1'b0, 1'b0, 1'b0, 5'h00);
        check("ei_bound_busy", 16'(int_busy), 16'h0);
        check("ei_bound_ime", 16'(ime), 16'h1);
        mstep(1'b1, 1'b0, 1'b0, 1'b0, 5'h00);
        check("ei_next_busy", 16'(int_busy), 16'h1);
        for (int i = 0; i < 5; i++) mstep(1'b0, 1'b0, 1'b0, 1'b0, 5'h00);
        check("ei_done_busy", 16'(int_busy), 16'h0);
        check("ei_vector", vector, 16'h0040);
        rd(16'hFF0F, d); check("ei_if", 16'(d), 16'h00E0);

        // EI;DI leaves IME clear.
        do_reset();
        wr(16'hFFFF, 8'h01);
        wr(16'hFF0F, 8'h01);
        mstep(1'b0, 1'b1, 1'b0, 1'b0, 5'h00);
        mstep(1'b0, 1'b0, 1'b1, 1'b0, 5'h00);
        mstep(1'b1, 1'b0, 1'b0, 1'b0, 5'h00);
        mstep(1'b1, 1'b0, 1'b0, 1'b0, 5'h00);
        check("eidi_ime", 16'(ime), 16'h0);
        check("eidi_busy", 16'(int_busy), 16'h0);

        // Cancel: IE cleared during the PCH push.
        do_reset();
        mstep(1'b0, 1'b0, 1'b0, 1'b1, 5'h00);
        wr(16'hFFFF, 8'h04);
        pulse_irq(5'h04);
        mstep(1'b1, 1'b0, 1'b0, 1'b0, 5'h00);
        mstep(1'b0, 1'b0, 1'b0, 1'b0, 5'h00);
        mstep(1'b0, 1'b0, 1'b0, 1'b0, 5'h00);
        check("cancel_in_ph", 16'(push_pch), 16'h1);
        wr(16'hFFFF, 8'h00);
        mstep(1'b0, 1'b0, 1'b0, 1'b0, 5'h00);
        mstep(1'b0, 1'b0, 1'b0, 1'b0, 5'h00);
        check("cancel_vec_load", 16'(vec_load), 16'h1);
        check("cancel_vector", vector, 16'h0000);
        mstep(1'b0, 1'b0, 1'b0, 1'b0, 5'h00);
        check("cancel_busy", 16'(int_busy), 16'h0);
        rd(16'hFF0F, d); check("cancel_if", 16'(d), 16'h00E4);

        // HALT wake with IME clear.
        do_reset();
        halted = 1'b1;
        wr(16'hFFFF, 8'h10);
        check("halt_wake_before", 16'(wake), 16'h0);
        pulse_irq(5'h10);
        check("halt_wake", 16'(wake), 16'h1);
        mstep(1'b1, 1'b0, 1'b0, 1'b0, 5'h00);
        check("halt_busy", 16'(int_busy), 16'h0);
        halted = 1'b0;

        // A fresh request at the LD step keeps its IF bit set.
        do_reset();
        mstep(1'b0, 1'b0, 1'b0, 1'b1, 5'h00);
        wr(16'hFFFF, 8'h01);
        pulse_irq(5'h01);
        mstep(1'b1, 1'b0, 1'b0, 1'b0, 5'h00);
        for (int i = 0; i < 4; i++) mstep(1'b0, 1'b0, 1'b0, 1'b0, 5'h00);
        check("ovr_in_ld", 16'(vec_load), 16'h1);
        mstep(1'b0, 1'b0, 1'b0, 1'b0, 5'h01);
        rd(16'hFF0F, d); check("ovr_if", 16'(d), 16'h00E1);

        // Asynchronous reset during PL.
        do_reset();
        mstep(1'b0, 1'b0, 1'b0, 1'b1, 5'h00);
        wr(16'hFFFF, 8'h01);
        pulse_irq(5'h01);
        mstep(1'b1, 1'b0, 1'b0, 1'b0, 5'h00);
        for (int i = 0; i < 3; i++) mstep(1'b0, 1'b0, 1'b0, 1'b0, 5'h00);
        check("rst_in_pl", 16'(push_pcl), 16'h1);
        rst = 1'b0;
        #1;
        check("rst_busy", 16'(int_busy), 16'h0);
        check("rst_strobes", 16'(strobes), 16'h0);
        check("rst_ime", 16'(ime), 16'h0);
        rd(16'hFF0F, d); check("rst_if", 16'(d), 16'h00E0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
